// File: rtl/alu_pkg.sv
// Shared constants and the decoded-entry bundle for the ALU issue stage.
// Covers ALUFun codes, MIPS opcode/funct values and the immediate-extension helpers.
package alu_pkg;
   localparam int ALU_DW = 32;
   localparam int ALU_RW = 5;

   localparam logic [5:0] FUN_ADD = 6'b000000;
   localparam logic [5:0] FUN_SUB = 6'b000001;
   localparam logic [5:0] FUN_AND = 6'b011000;
   localparam logic [5:0] FUN_OR  = 6'b011110;
   localparam logic [5:0] FUN_XOR = 6'b010110;
   localparam logic [5:0] FUN_NOR = 6'b010001;
   localparam logic [5:0] FUN_SLL = 6'b100000;
   localparam logic [5:0] FUN_SRL = 6'b100001;
   localparam logic [5:0] FUN_SRA = 6'b100011;
   localparam logic [5:0] FUN_EQ  = 6'b110011;
   localparam logic [5:0] FUN_NEQ = 6'b110001;
   localparam logic [5:0] FUN_LT  = 6'b110101;
   localparam logic [5:0] FUN_LEZ = 6'b111101;
   localparam logic [5:0] FUN_LTZ = 6'b111011;
   localparam logic [5:0] FUN_GTZ = 6'b111111;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0a;
   localparam logic [5:0] OP_SLTIU  = 6'h0b;
   localparam logic [5:0] OP_ANDI   = 6'h0c;
   localparam logic [5:0] OP_ORI    = 6'h0d;
   localparam logic [5:0] OP_XORI   = 6'h0e;
   localparam logic [5:0] OP_LUI    = 6'h0f;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2b;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_SRAV = 6'h07;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_JALR = 6'h09;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2a;
   localparam logic [5:0] F_SLTU = 6'h2b;

   typedef struct packed {
      logic [ALU_DW-1:0] a;
      logic [ALU_DW-1:0] b;
      logic [5:0]        fun;
      logic              sign;
      logic [ALU_RW-1:0] dest;
      logic              illegal;
   } alu_entry_t;

   function automatic logic [ALU_DW-1:0] sext16(input logic [15:0] imm);
      return {{(ALU_DW-16){imm[15]}}, imm};
   endfunction

   function automatic logic [ALU_DW-1:0] zext16(input logic [15:0] imm);
      return {{(ALU_DW-16){1'b0}}, imm};
   endfunction
endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decode: instruction plus forwarded operands into one ALU entry.
// Unrecognised encodings collapse to an all-zero ADD entry flagged illegal.
module alu_decode
   import alu_pkg::*;
(
   input  logic [31:0]       instr,
   input  logic [ALU_DW-1:0] rs_val,
   input  logic [ALU_DW-1:0] rt_val,
   output alu_entry_t        entry
);
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic        bad;
   logic        unused_rs_field;
   alu_entry_t  e;

   assign op              = instr[31:26];
   assign rt              = instr[20:16];
   assign rd              = instr[15:11];
   assign shamt           = instr[10:6];
   assign funct           = instr[5:0];
   assign imm             = instr[15:0];
   assign unused_rs_field = ^instr[25:21];

   always_comb begin
      e      = '0;
      e.a    = rs_val;
      e.b    = rt_val;
      e.fun  = FUN_ADD;
      bad    = 1'b0;
      case (op)
         OP_RTYPE: begin
            e.dest = rd;
            case (funct)
               F_ADD:  begin e.fun = FUN_ADD; e.sign = 1'b1; end
               F_ADDU: e.fun = FUN_ADD;
               F_SUB:  begin e.fun = FUN_SUB; e.sign = 1'b1; end
               F_SUBU: e.fun = FUN_SUB;
               F_AND:  e.fun = FUN_AND;
               F_OR:   e.fun = FUN_OR;
               F_XOR:  e.fun = FUN_XOR;
               F_NOR:  e.fun = FUN_NOR;
               F_SLT:  begin e.fun = FUN_LT; e.sign = 1'b1; end
               F_SLTU: e.fun = FUN_LT;
               F_SLL:  begin e.fun = FUN_SLL; e.a = {{(ALU_DW-5){1'b0}}, shamt}; end
               F_SRL:  begin e.fun = FUN_SRL; e.a = {{(ALU_DW-5){1'b0}}, shamt}; end
               F_SRA:  begin e.fun = FUN_SRA; e.a = {{(ALU_DW-5){1'b0}}, shamt}; end
               F_SLLV: e.fun = FUN_SLL;
               F_SRLV: e.fun = FUN_SRL;
               F_SRAV: e.fun = FUN_SRA;
               F_JR:   e.dest = '0;
               F_JALR: e.fun = FUN_ADD;
               default: bad = 1'b1;
            endcase
         end
         OP_ADDI:  begin e.b = sext16(imm); e.sign = 1'b1; e.dest = rt; end
         OP_ADDIU: begin e.b = sext16(imm); e.dest = rt; end
         OP_SLTI:  begin e.b = sext16(imm); e.sign = 1'b1; e.fun = FUN_LT; e.dest = rt; end
         OP_SLTIU: begin e.b = sext16(imm); e.fun = FUN_LT; e.dest = rt; end
         OP_ANDI:  begin e.b = zext16(imm); e.fun = FUN_AND; e.dest = rt; end
         OP_ORI:   begin e.b = zext16(imm); e.fun = FUN_OR;  e.dest = rt; end
         OP_XORI:  begin e.b = zext16(imm); e.fun = FUN_XOR; e.dest = rt; end
         OP_LUI:   begin e.a = '0; e.b = {imm, 16'b0}; e.dest = rt; end
         OP_LW:    begin e.b = sext16(imm); e.dest = rt; end
         OP_SW:    e.b = sext16(imm);
         OP_BEQ:   begin e.fun = FUN_EQ;  e.sign = 1'b1; end
         OP_BNE:   begin e.fun = FUN_NEQ; e.sign = 1'b1; end
         OP_BLEZ:  begin e.fun = FUN_LEZ; e.sign = 1'b1; e.b = '0; end
         OP_BGTZ:  begin e.fun = FUN_GTZ; e.sign = 1'b1; e.b = '0; end
         OP_REGIMM: begin
            // Only bltz (rt == 0) is supported from the REGIMM group.
            if (rt == 5'd0) begin
               e.fun = FUN_LTZ; e.sign = 1'b1; e.b = '0;
            end else begin
               bad = 1'b1;
            end
         end
         OP_J:     begin e.a = '0; e.b = '0; end
         OP_JAL:   begin e.a = '0; e.b = '0; e.dest = 5'd31; end
         default:  bad = 1'b1;
      endcase
      if (bad) begin
         e         = '0;
         e.illegal = 1'b1;
      end
   end

   assign entry = e;
endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes into a registered output slot backed by a one-entry skid,
// so in_ready comes straight from a flop and ordering is always preserved.
module alu_issue
   import alu_pkg::*;
#(
   parameter int DW = ALU_DW,
   parameter int RW = ALU_RW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   instr,
   input  logic [DW-1:0] rs_val,
   input  logic [DW-1:0] rt_val,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [5:0]    alu_fun,
   output logic          alu_sign,
   output logic [RW-1:0] dest,
   output logic          illegal
);
   alu_entry_t dec;
   alu_entry_t out_q, out_d, skid_q, skid_d;
   logic       out_valid_q, out_valid_d;
   logic       skid_valid_q, skid_valid_d;
   logic       in_ready_q, in_ready_d;
   logic       accept, consume;

   alu_decode u_decode (
      .instr  (instr),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .entry  (dec)
   );

   assign accept  = in_valid & in_ready_q;
   assign consume = out_valid_q & out_ready;

   // Handshake: a transfer happens on any rising edge where valid and ready are both high.
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         if (consume) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!out_valid_q || consume) begin
            out_d       = dec;
            out_valid_d = 1'b1;
         end else begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
         end
      end else if (consume) begin
         out_valid_d = 1'b0;
      end
      in_ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign alu_a     = out_q.a;
   assign alu_b     = out_q.b;
   assign alu_fun   = out_q.fun;
   assign alu_sign  = out_q.sign;
   assign dest      = out_q.dest;
   assign illegal   = out_q.illegal;
endmodule
